// File: rtl/mem_arbiter.sv
// N-port memory arbiter: one-deep request slot per port, round-robin grant onto a single Memory port.
// Define MEM_ARBITER_FIXED_PRIORITY_EN to make the lowest-index pending port always win instead.
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             req_cmd_start,
    input  logic [NUM_PORTS-1:0]             req_cmd_write,
    output logic [NUM_PORTS-1:0]             req_cmd_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wmask,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  req_rdata,
    output logic [NUM_PORTS-1:0]             req_rdata_valid,
    output logic                             mem_cmd_start,
    output logic                             mem_cmd_write,
    input  logic                             mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic [DATA_WIDTH-1:0]            mem_wmask,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    input  logic                             mem_rdata_valid,
    output logic                             dbg_state
);

    // Handshakes: a requester transfers when req_cmd_start[i] && req_cmd_ready[i] in the same
    // cycle; the Memory port transfers when mem_cmd_start && mem_cmd_ready (start is never raised
    // without ready, and mem_* are zero whenever start is low). Read data is a one-cycle pulse.

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_READ = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    ptr_t                   rr_ptr_q, rr_ptr_d;
    ptr_t                   cur_q, cur_d;
    logic [NUM_PORTS-1:0]   pending_q, pending_d;
    logic [NUM_PORTS-1:0]   write_q, write_d;
    logic [NUM_PORTS-1:0]   rdata_valid_q, rdata_valid_d;
    logic [ADDR_WIDTH-1:0]  addr_q  [NUM_PORTS];
    logic [ADDR_WIDTH-1:0]  addr_d  [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_d [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wmask_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  wmask_d [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  rdata_q [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  rdata_d [NUM_PORTS];

    ptr_t grant;
    ptr_t next_ptr;
    logic grant_found;
    logic any_pending;
    logic issue;

    // Grant search: first pending slot at or after the round-robin pointer.
    always_comb begin
        int   idx;
        ptr_t idx_p;
        idx         = 0;
        idx_p       = '0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
`endif
            idx_p = ptr_t'(idx);
            if (!grant_found && pending_q[idx_p]) begin
                grant_found = 1'b1;
                grant       = idx_p;
            end
        end
    end

    assign any_pending = |pending_q;
    assign next_ptr    = ptr_t'((int'(grant) + 1) % NUM_PORTS);
    assign issue       = (state_q == ST_IDLE) && any_pending && mem_cmd_ready && !reset;

    assign mem_cmd_start = issue;
    assign mem_cmd_write = issue ? write_q[grant] : 1'b0;
    assign mem_addr      = issue ? addr_q[grant]  : '0;
    assign mem_wdata     = issue ? wdata_q[grant] : '0;
    assign mem_wmask     = issue ? wmask_q[grant] : '0;

    assign req_cmd_ready   = ~pending_q;
    assign req_rdata_valid = rdata_valid_q;
    assign dbg_state       = state_q;

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rdata_out
        assign req_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q[gi];
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cur_d         = cur_q;
        pending_d     = pending_q;
        write_d       = write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        rdata_valid_d = '0;

        // A slot only accepts while empty, so accept never collides with completion of that slot.
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_cmd_start[i] && !pending_q[i]) begin
                pending_d[i] = 1'b1;
                write_d[i]   = req_cmd_write[i];
                addr_d[i]    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_d[i]   = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                wmask_d[i]   = req_wmask[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (issue) begin
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
                    rr_ptr_d = next_ptr;
`endif
                    if (write_q[grant]) begin
                        pending_d[grant] = 1'b0;
                    end else begin
                        cur_d   = grant;
                        state_d = ST_WAIT_READ;
                    end
                end
            end
            ST_WAIT_READ: begin
                if (mem_rdata_valid) begin
                    rdata_d[cur_q]       = mem_rdata;
                    rdata_valid_d[cur_q] = 1'b1;
                    pending_d[cur_q]     = 1'b0;
                    state_d              = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            cur_q         <= '0;
            pending_q     <= '0;
            write_q       <= '0;
            rdata_valid_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                wmask_q[i] <= '0;
                rdata_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cur_q         <= cur_d;
            pending_q     <= pending_d;
            write_q       <= write_d;
            rdata_valid_q <= rdata_valid_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                addr_q[i]  <= addr_d[i];
                wdata_q[i] <= wdata_d[i];
                wmask_q[i] <= wmask_d[i];
                rdata_q[i] <= rdata_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected Memory commands and read returns are queued at stimulus
// time and a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NP    = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CMD_W = 1 + AW + 2*DW;
    localparam int RD_W  = 8 + DW;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_cmd_start;
    logic [NP-1:0]     req_cmd_write;
    logic [NP-1:0]     req_cmd_ready;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP*DW-1:0]  req_wmask;
    logic [NP*DW-1:0]  req_rdata;
    logic [NP-1:0]     req_rdata_valid;
    logic              mem_cmd_start;
    logic              mem_cmd_write;
    logic              mem_cmd_ready;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_wmask;
    logic [DW-1:0]     mem_rdata;
    logic              mem_rdata_valid;
    logic              dbg_state;

    logic [CMD_W-1:0]  exp_cmd_q[$];
    logic [RD_W-1:0]   exp_rd_q[$];
    logic [DW-1:0]     rsp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_cmd_start   (req_cmd_start),
        .req_cmd_write   (req_cmd_write),
        .req_cmd_ready   (req_cmd_ready),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wmask       (req_wmask),
        .req_rdata       (req_rdata),
        .req_rdata_valid (req_rdata_valid),
        .mem_cmd_start   (mem_cmd_start),
        .mem_cmd_write   (mem_cmd_write),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wmask       (mem_wmask),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .dbg_state       (dbg_state)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_cmd_start[p]        = 1'b1;
        req_cmd_write[p]        = w;
        req_addr[p*AW +: AW]    = a;
        req_wdata[p*DW +: DW]   = d;
        req_wmask[p*DW +: DW]   = m;
    endtask

    task automatic pulse();
        step();
        req_cmd_start = '0;
    endtask

    task automatic push_cmd(input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        exp_cmd_q.push_back({w, a, d, m});
    endtask

    task automatic push_rd(input int p, input logic [DW-1:0] d);
        exp_rd_q.push_back({8'(p), d});
    endtask

    task automatic wait_rd(input int p);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (req_rdata_valid[p]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rd_timeout: port %0d saw no rdata_valid, required within 40 cycles", p);
        end
        step();
    endtask

    // Memory model: answers each read command three cycles later with the next queued response.
    task automatic mem_model();
        logic [DW-1:0] rsp;
        forever begin
            @(negedge clk);
            if (mem_cmd_start && !mem_cmd_write) begin
                rsp = '0;
                if (rsp_q.size() != 0) rsp = rsp_q.pop_front();
                repeat (3) @(posedge clk);
                #1;
                mem_rdata       = rsp;
                mem_rdata_valid = 1'b1;
                @(posedge clk);
                #1;
                mem_rdata_valid = 1'b0;
                mem_rdata       = '0;
            end
        end
    endtask

    task automatic monitor();
        logic [CMD_W-1:0] ec;
        logic [RD_W-1:0]  er;
        forever begin
            @(negedge clk);
            if (mem_cmd_start) begin
                checks++;
                if (exp_cmd_q.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected: got cmd write=%0d addr=0x%0h, expected none",
                             mem_cmd_write, mem_addr);
                end else begin
                    ec = exp_cmd_q.pop_front();
                    chk("mem_cmd", {mem_cmd_write, mem_addr, mem_wdata, mem_wmask}, ec);
                end
            end else begin
                chk("mem_idle_zero", {mem_cmd_write, mem_addr, mem_wdata, mem_wmask}, '0);
            end
            for (int p = 0; p < NP; p++) begin
                if (req_rdata_valid[p]) begin
                    checks++;
                    if (exp_rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rdata_unexpected: port %0d valid data 0x%0h, expected no pulse",
                                 p, req_rdata[p*DW +: DW]);
                    end else begin
                        er = exp_rd_q.pop_front();
                        chk("rdata", {8'(p), req_rdata[p*DW +: DW]}, er);
                    end
                end
            end
        end
    endtask

    initial begin
        reset           = 1'b1;
        req_cmd_start   = '0;
        req_cmd_write   = '0;
        req_addr        = '0;
        req_wdata       = '0;
        req_wmask       = '0;
        mem_cmd_ready   = 1'b1;
        mem_rdata       = '0;
        mem_rdata_valid = 1'b0;

        fork
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached, expected completion");
                $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
                $fatal(1);
            end
        join_none

        // Reset
        repeat (2) step();
        reset = 1'b0;
        chk("reset_ready", req_cmd_ready, 2'b11);
        chk("reset_rdata_valid", req_rdata_valid, 2'b00);
        chk("reset_mem_start", mem_cmd_start, 1'b0);
        chk("reset_rdata", req_rdata, '0);
        chk("reset_state", dbg_state, 1'b0);

        fork
            mem_model();
            monitor();
        join_none

        // Single read on port 1
        rsp_q.push_back(32'hDEADBEEF);
        push_cmd(1'b0, 32'h100, '0, '0);
        push_rd(1, 32'hDEADBEEF);
        set_req(1, 1'b0, 32'h100, '0, '0);
        pulse();
        chk("rd1_ready_busy", req_cmd_ready, 2'b01);
        wait_rd(1);
        chk("rd1_pulse_one_cycle", req_rdata_valid, 2'b00);
        chk("rd1_rdata_held", req_rdata[1*DW +: DW], 32'hDEADBEEF);
        chk("rd1_port0_unchanged", req_rdata[0 +: DW], 32'h0);
        chk("rd1_ready_back", req_cmd_ready, 2'b11);

        // Simultaneous reads, twice: grant order 0,1,0,1
        for (int r = 0; r < 2; r++) begin
            rsp_q.push_back(32'hA0000000 + r);
            rsp_q.push_back(32'hB1000000 + r);
            push_cmd(1'b0, 32'h200 + 4*r, '0, '0);
            push_cmd(1'b0, 32'h300 + 4*r, '0, '0);
            push_rd(0, 32'hA0000000 + r);
            push_rd(1, 32'hB1000000 + r);
            set_req(0, 1'b0, 32'h200 + 4*r, '0, '0);
            set_req(1, 1'b0, 32'h300 + 4*r, '0, '0);
            pulse();
            wait_rd(1);
            chk("rr_rd_port0_data", req_rdata[0 +: DW], 32'hA0000000 + r);
            chk("rr_rd_ready_back", req_cmd_ready, 2'b11);
        end

        // Port 0 write
        push_cmd(1'b1, 32'h40, 32'h12345678, 32'hFFFF0000);
        set_req(0, 1'b1, 32'h40, 32'h12345678, 32'hFFFF0000);
        pulse();
        chk("wr_issue_now", mem_cmd_start, 1'b1);
        chk("wr_ready_busy", req_cmd_ready[0], 1'b0);
        step();
        chk("wr_ready_back", req_cmd_ready[0], 1'b1);
        chk("wr_no_rdata_valid", req_rdata_valid, 2'b00);

        // Both ports write after port 0 was last granted
`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
        push_cmd(1'b1, 32'h84, 32'h11112222, 32'hFFFFFFFF);
        push_cmd(1'b1, 32'h80, 32'hAAAA5555, 32'h0000FFFF);
`else
        push_cmd(1'b1, 32'h80, 32'hAAAA5555, 32'h0000FFFF);
        push_cmd(1'b1, 32'h84, 32'h11112222, 32'hFFFFFFFF);
`endif
        set_req(1, 1'b1, 32'h80, 32'hAAAA5555, 32'h0000FFFF);
        set_req(0, 1'b1, 32'h84, 32'h11112222, 32'hFFFFFFFF);
        pulse();
        step();
        step();
        chk("wr2_ready_back", req_cmd_ready, 2'b11);

        // Memory stalls for 5 cycles with a pending read; a start while busy is ignored
        mem_cmd_ready = 1'b0;
        rsp_q.push_back(32'hCAFEF00D);
        push_cmd(1'b0, 32'h500, '0, '0);
        push_rd(0, 32'hCAFEF00D);
        set_req(0, 1'b0, 32'h500, '0, '0);
        pulse();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) set_req(0, 1'b0, 32'h5F0, '0, '0);
            chk("stall_no_start", mem_cmd_start, 1'b0);
            chk("stall_ready_low", req_cmd_ready[0], 1'b0);
            step();
            req_cmd_start = '0;
        end
        mem_cmd_ready = 1'b1;
        #1;
        chk("stall_release_issue", mem_cmd_start, 1'b1);
        wait_rd(0);
        chk("stall_rdata", req_rdata[0 +: DW], 32'hCAFEF00D);

        // Reset while a read is outstanding; the late response must be dropped
        rsp_q.push_back(32'h0BADBAD0);
        push_cmd(1'b0, 32'h600, '0, '0);
        set_req(1, 1'b0, 32'h600, '0, '0);
        pulse();
        step();
        chk("wait_read_state", dbg_state, 1'b1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_reset_ready", req_cmd_ready, 2'b11);
            chk("post_reset_no_valid", req_rdata_valid, 2'b00);
            step();
        end
        chk("post_reset_rdata", req_rdata, '0);
        chk("post_reset_state", dbg_state, 1'b0);

        repeat (2) step();
        chk("cmd_q_drained", exp_cmd_q.size(), 0);
        chk("rd_q_drained", exp_rd_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
